// File: rtl/slot_pkg.sv
// Shared encodings and helpers for the slot win chase block.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package slot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHASE = 2'd1,
    ST_LOSE  = 2'd2
  } state_e;

  // Ceiling log2, used to size the prescaler counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/slot_tick_gen.sv
// Free-running prescaler: raises tick for one clk every TICK_DIV cycles.
// Latency: tick is high while the counter holds TICK_DIV-1 (first tick TICK_DIV clks after reset release).
// Backpressure: none; never stalls and is not restarted by any input.
module slot_tick_gen
  import slot_pkg::*;
#(
  parameter int TICK_DIV = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // tick marks the final count; TICK_DIV=1 keeps the counter at 0 so tick is constant 1
  always_comb begin
    tick  = (cnt_q == LAST);
    cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
  end

  // Counter register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/slot_win_chase.sv
// Reel judge: on each prescaler tick, chases a green LED while stopped reels match, latches red on a mismatch.
// Latency: outputs update on the clk edge that ends the tick cycle (1 clk after tick).
// Backpressure: none; reels/stop are sampled only on tick, changes between ticks are ignored.
module slot_win_chase
  import slot_pkg::*;
#(
  parameter int N_REELS   = 3,
  parameter int DIGIT_W   = 4,
  parameter int LED_W     = 8,
  parameter int TICK_DIV  = 1048576,
  parameter int WRAP      = 1,
  parameter int PAIR_MODE = 0,
  parameter int LAP_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REELS*DIGIT_W-1:0]   reels,
  input  logic                         stop,
  output logic [LED_W-1:0]             gled,
  output logic                         rled,
  output logic                         win,
  output logic [LAP_W-1:0]             laps
);

  logic tick;
  logic match;

  slot_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  if (PAIR_MODE == 0) begin : g_all
    // Every reel must equal reel 0
    logic [N_REELS-1:0] eq;
    for (genvar k = 0; k < N_REELS; k++) begin : g_eq
      assign eq[k] = (reels[k*DIGIT_W +: DIGIT_W] == reels[0 +: DIGIT_W]);
    end
    assign match = &eq;
  end else begin : g_pair
    // Any pair i<j equal; the lower triangle and diagonal are tied off
    logic [N_REELS*N_REELS-1:0] hit;
    for (genvar i = 0; i < N_REELS; i++) begin : g_i
      for (genvar j = 0; j < N_REELS; j++) begin : g_j
        if (j > i) begin : g_cmp
          assign hit[i*N_REELS+j] =
            (reels[i*DIGIT_W +: DIGIT_W] == reels[j*DIGIT_W +: DIGIT_W]);
        end else begin : g_off
          assign hit[i*N_REELS+j] = 1'b0;
        end
      end
    end
    assign match = |hit;
  end

  state_e           state_q, state_d;
  logic [LED_W-1:0] gled_q, gled_d;
  logic             rled_q, rled_d;
  logic             win_q, win_d;
  logic [LAP_W-1:0] laps_q, laps_d;

  // Next-state and output decode; only tick cycles can move anything, and !stop always wins
  always_comb begin
    state_d = state_q;
    gled_d  = gled_q;
    rled_d  = rled_q;
    win_d   = 1'b0;
    laps_d  = laps_q;
    if (tick) begin
      if (!stop) begin
        state_d = ST_IDLE;
        gled_d  = '0;
        rled_d  = 1'b0;
        laps_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (match) begin
              state_d = ST_CHASE;
              gled_d  = LED_W'(1);
            end else begin
              state_d = ST_LOSE;
              rled_d  = 1'b1;
            end
          end
          ST_CHASE: begin
            if (!match) begin
              // gled is left frozen where the mismatch caught it
              state_d = ST_LOSE;
              rled_d  = 1'b1;
            end else if (gled_q[LED_W-1]) begin
              if (WRAP != 0) begin
                gled_d = LED_W'(1);
                if (laps_q != '1) begin
                  laps_d = laps_q + LAP_W'(1);
                end
              end
            end else begin
              gled_d = gled_q << 1;
              // gled is one-hot, so the bit below the MSB moving up is an MSB entry
              win_d  = gled_q[LED_W-2];
            end
          end
          ST_LOSE: begin
            state_d = ST_LOSE;
          end
          default: begin
            state_d = ST_IDLE;
            gled_d  = '0;
            rled_d  = 1'b0;
            laps_d  = '0;
          end
        endcase
      end
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gled_q  <= '0;
      rled_q  <= 1'b0;
      win_q   <= 1'b0;
      laps_q  <= '0;
    end else begin
      state_q <= state_d;
      gled_q  <= gled_d;
      rled_q  <= rled_d;
      win_q   <= win_d;
      laps_q  <= laps_d;
    end
  end

  assign gled = gled_q;
  assign rled = rled_q;
  assign win  = win_q;
  assign laps = laps_q;

endmodule

// File: tb/tb_slot_win_chase.sv
// Directed bench for slot_win_chase: wrapping, non-wrapping and pair-mode instances.
// Latency: each step is one full tick period (4 clks) ending just after the tick edge.
// Backpressure: n/a.
module tb_slot_win_chase;

  logic        clk;
  logic        rst_n;
  logic [11:0] reels_a, reels_p;
  logic        stop_a, stop_p;

  logic [3:0]  gled_a, gled_b, gled_p;
  logic        rled_a, rled_b, rled_p;
  logic        win_a, win_b, win_p;
  logic [1:0]  laps_a, laps_b, laps_p;

  int n_vec;
  int n_err;
  int wa, wb, wp;

  slot_win_chase #(.N_REELS(3), .DIGIT_W(4), .LED_W(4), .TICK_DIV(4),
                   .WRAP(1), .PAIR_MODE(0), .LAP_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .reels(reels_a), .stop(stop_a),
    .gled(gled_a), .rled(rled_a), .win(win_a), .laps(laps_a));

  slot_win_chase #(.N_REELS(3), .DIGIT_W(4), .LED_W(4), .TICK_DIV(4),
                   .WRAP(0), .PAIR_MODE(0), .LAP_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .reels(reels_a), .stop(stop_a),
    .gled(gled_b), .rled(rled_b), .win(win_b), .laps(laps_b));

  slot_win_chase #(.N_REELS(3), .DIGIT_W(4), .LED_W(4), .TICK_DIV(4),
                   .WRAP(1), .PAIR_MODE(1), .LAP_W(2)) u_p (
    .clk(clk), .rst_n(rst_n), .reels(reels_p), .stop(stop_p),
    .gled(gled_p), .rled(rled_p), .win(win_p), .laps(laps_p));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pack(input logic [3:0] r0, input logic [3:0] r1,
                                       input logic [3:0] r2);
    return {r2, r1, r0};
  endfunction

  // One tick period: four edges, sampling 1 time unit after each, collecting win pulses
  task automatic step();
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      wa += int'(win_a);
      wb += int'(win_b);
      wp += int'(win_p);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    reels_a = '0;
    reels_p = '0;
    stop_a  = 1'b0;
    stop_p  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({gled_a, rled_a, win_a, laps_a} !== 8'h00) begin
      $display("FAIL reset_a: got %b expected 00000000", {gled_a, rled_a, win_a, laps_a});
      n_err++;
    end
    n_vec++;
    if ({gled_p, rled_p, win_p, laps_p} !== 8'h00) begin
      $display("FAIL reset_p: got %b expected 00000000", {gled_p, rled_p, win_p, laps_p});
      n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_chase_wrap();
    logic [3:0] exp_a [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [3:0] exp_b [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b1000};
    int         exp_w [6] = '{0, 0, 0, 1, 0, 0};
    logic [1:0] exp_l [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    reels_a = pack(4'd5, 4'd5, 4'd5);
    stop_a  = 1'b1;
    for (int s = 0; s < 6; s++) begin
      wa = 0;
      wb = 0;
      step();
      n_vec++;
      if (gled_a !== exp_a[s]) begin
        $display("FAIL wrap_gled step %0d: got %b expected %b", s, gled_a, exp_a[s]);
        n_err++;
      end
      n_vec++;
      if (gled_b !== exp_b[s]) begin
        $display("FAIL nowrap_gled step %0d: got %b expected %b", s, gled_b, exp_b[s]);
        n_err++;
      end
      n_vec++;
      if (wa !== exp_w[s] || wb !== exp_w[s]) begin
        $display("FAIL win_pulses step %0d: got %0d/%0d expected %0d", s, wa, wb, exp_w[s]);
        n_err++;
      end
      n_vec++;
      if (laps_a !== exp_l[s] || laps_b !== 2'd0) begin
        $display("FAIL laps step %0d: got %0d/%0d expected %0d/0", s, laps_a, laps_b, exp_l[s]);
        n_err++;
      end
    end
    stop_a = 1'b0;
    step();
    n_vec++;
    if ({gled_a, rled_a, laps_a, gled_b, laps_b} !== 13'h0) begin
      $display("FAIL chase_clear: got %b expected 0", {gled_a, rled_a, laps_a, gled_b, laps_b});
      n_err++;
    end
  endtask

  task automatic test_lose();
    reels_a = pack(4'd5, 4'd5, 4'd5);
    stop_a  = 1'b1;
    step();
    step();
    reels_a = pack(4'd5, 4'd5, 4'd6);
    step();
    n_vec++;
    if (gled_a !== 4'b0010 || rled_a !== 1'b1) begin
      $display("FAIL lose_freeze: got gled=%b rled=%b expected gled=0010 rled=1", gled_a, rled_a);
      n_err++;
    end
    reels_a = pack(4'd5, 4'd5, 4'd5);
    step();
    n_vec++;
    if (gled_a !== 4'b0010 || rled_a !== 1'b1) begin
      $display("FAIL lose_hold: got gled=%b rled=%b expected gled=0010 rled=1", gled_a, rled_a);
      n_err++;
    end
    stop_a = 1'b0;
    step();
    n_vec++;
    if (gled_a !== 4'b0000 || rled_a !== 1'b0) begin
      $display("FAIL lose_clear: got gled=%b rled=%b expected gled=0000 rled=0", gled_a, rled_a);
      n_err++;
    end
  endtask

  task automatic test_pair();
    reels_p = pack(4'd3, 4'd7, 4'd3);
    stop_p  = 1'b1;
    step();
    step();
    n_vec++;
    if (gled_p !== 4'b0010 || rled_p !== 1'b0) begin
      $display("FAIL pair_chase: got gled=%b rled=%b expected gled=0010 rled=0", gled_p, rled_p);
      n_err++;
    end
    stop_p = 1'b0;
    step();
    reels_p = pack(4'd1, 4'd2, 4'd3);
    stop_p  = 1'b1;
    step();
    n_vec++;
    if (gled_p !== 4'b0000 || rled_p !== 1'b1) begin
      $display("FAIL pair_lose: got gled=%b rled=%b expected gled=0000 rled=1", gled_p, rled_p);
      n_err++;
    end
    stop_p = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    reels_a = pack(4'd5, 4'd5, 4'd5);
    stop_a  = 1'b1;
    repeat (5) step();
    n_vec++;
    if (gled_a !== 4'b0001 || laps_a !== 2'd1) begin
      $display("FAIL pre_reset: got gled=%b laps=%0d expected gled=0001 laps=1", gled_a, laps_a);
      n_err++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({gled_a, rled_a, win_a, laps_a} !== 8'h00) begin
      $display("FAIL async_reset: got %b expected 00000000", {gled_a, rled_a, win_a, laps_a});
      n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (gled_a !== 4'b0000) begin
      $display("FAIL early_tick: got gled=%b expected 0000", gled_a);
      n_err++;
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (gled_a !== 4'b0001) begin
      $display("FAIL first_tick: got gled=%b expected 0001", gled_a);
      n_err++;
    end
  endtask

  task automatic test_between_ticks();
    // Glitch stop/reels inside one period; the tick edge must still see a match
    @(posedge clk);
    #1;
    stop_a  = 1'b0;
    reels_a = pack(4'd1, 4'd2, 4'd3);
    @(posedge clk);
    #1;
    n_vec++;
    if (gled_a !== 4'b0001 || rled_a !== 1'b0) begin
      $display("FAIL glitch_mid: got gled=%b rled=%b expected gled=0001 rled=0", gled_a, rled_a);
      n_err++;
    end
    stop_a  = 1'b1;
    reels_a = pack(4'd5, 4'd5, 4'd5);
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (gled_a !== 4'b0010 || rled_a !== 1'b0) begin
      $display("FAIL glitch_tick: got gled=%b rled=%b expected gled=0010 rled=0", gled_a, rled_a);
      n_err++;
    end
    stop_a  = 1'b0;
    reels_a = pack(4'd5, 4'd5, 4'd6);
    step();
    n_vec++;
    if (gled_a !== 4'b0000 || rled_a !== 1'b0) begin
      $display("FAIL stop_priority: got gled=%b rled=%b expected gled=0000 rled=0", gled_a, rled_a);
      n_err++;
    end
    reels_a = pack(4'd5, 4'd5, 4'd5);
    stop_a  = 1'b1;
    wa = 0;
    for (int s = 1; s <= 21; s++) begin
      step();
      if (s % 4 == 1) begin
        n_vec++;
        if (laps_a !== 2'((s - 1) / 4 > 3 ? 3 : (s - 1) / 4) || gled_a !== 4'b0001) begin
          $display("FAIL lap_sat step %0d: got laps=%0d gled=%b expected laps=%0d gled=0001",
                   s, laps_a, gled_a, ((s - 1) / 4 > 3 ? 3 : (s - 1) / 4));
          n_err++;
        end
      end
    end
    n_vec++;
    if (wa !== 5) begin
      $display("FAIL lap_wins: got %0d expected 5", wa);
      n_err++;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    wa = 0;
    wb = 0;
    wp = 0;
    test_reset();
    test_chase_wrap();
    test_lose();
    test_pair();
    test_reset_mid();
    test_between_ticks();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
